// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line responder: receives and validates 48-bit host commands and
// serializes 48-bit or 136-bit responses after a programmable Ncr gap.
module sd_cmd_responder #(
  parameter int NCR = 2
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         icmd_sd,
  output logic         ocmd_sd,
  output logic         ocmd_valid,
  output logic [5:0]   ocmd_index,
  output logic [31:0]  ocmd_arg,
  output logic         ocmd_err,
  input  logic         iresp_start,
  input  logic         iresp_long,
  input  logic         iresp_nocrc,
  input  logic [119:0] iresp_bits,
  output logic         oresp_done,
  output logic         obusy
);

  typedef enum logic [2:0] {IDLE, RCV_CMD, WAIT_RESP, GAP, SEND} state_e;

  localparam logic [7:0] GAP_LOAD = 8'(NCR - 1);

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [135:0]   sr_q, sr_d;
  logic           cmd_sd_q, cmd_sd_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic           start_q, start_d;
  logic           long_q, long_d;
  logic [5:0]     index_q, index_d;
  logic [31:0]    arg_q, arg_d;

  logic [47:0]    rx_frame;
  logic           rx_ok;
  logic           resp_edge;
  logic [6:0]     short_crc, long_crc;
  logic [135:0]   tx_frame;

  // Leading zeros leave a zero-initialised CRC untouched, so one 120-bit walker serves all lengths.
  function automatic logic [6:0] crc7(input logic [119:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:3], c[2] ^ fb, c[1:0], fb};
    end
    return c;
  endfunction

  always_comb begin
    rx_frame  = {sr_q[46:0], icmd_sd};
    rx_ok     = rx_frame[46] && rx_frame[0] &&
                (crc7({80'd0, rx_frame[47:8]}) == rx_frame[7:1]);
    resp_edge = iresp_start & ~start_q;
    short_crc = iresp_nocrc ? 7'h7F : crc7({82'd0, iresp_bits[37:0]});
    long_crc  = iresp_nocrc ? 7'h7F : crc7(iresp_bits);
    tx_frame  = iresp_long ? {8'h3F, iresp_bits, long_crc, 1'b1}
                           : {2'b00, iresp_bits[37:0], short_crc, 1'b1, 88'd0};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    cmd_sd_d = 1'b1;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    start_d  = iresp_start;
    long_d   = long_q;
    index_d  = index_q;
    arg_d    = arg_q;

    case (state_q)
      IDLE: begin
        if (!icmd_sd) begin
          state_d = RCV_CMD;
          cnt_d   = 8'd47;
          sr_d    = {sr_q[134:0], icmd_sd};
        end
      end
      RCV_CMD: begin
        sr_d = {sr_q[134:0], icmd_sd};
        if (cnt_q == 8'd1) begin
          cnt_d = '0;
          if (rx_ok) begin
            state_d = WAIT_RESP;
            valid_d = 1'b1;
            index_d = rx_frame[45:40];
            arg_d   = rx_frame[39:8];
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      // A fresh request wins over a line-low seen in the same cycle.
      WAIT_RESP: begin
        if (resp_edge) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          sr_d    = tx_frame;
          long_d  = iresp_long;
        end else if (!icmd_sd) begin
          state_d = RCV_CMD;
          cnt_d   = 8'd47;
          sr_d    = {sr_q[134:0], icmd_sd};
        end
      end
      GAP: begin
        if (cnt_q == 8'd1) begin
          state_d  = SEND;
          cmd_sd_d = sr_q[135];
          sr_d     = {sr_q[134:0], 1'b1};
          cnt_d    = long_q ? 8'd136 : 8'd48;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SEND: begin
        if (cnt_q == 8'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cmd_sd_d = sr_q[135];
          sr_d     = {sr_q[134:0], 1'b1};
          cnt_d    = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      cmd_sd_q <= 1'b1;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      long_q   <= 1'b0;
      index_q  <= '0;
      arg_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      cmd_sd_q <= cmd_sd_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      done_q   <= done_d;
      start_q  <= start_d;
      long_q   <= long_d;
      index_q  <= index_d;
      arg_q    <= arg_d;
    end
  end

  assign ocmd_sd    = cmd_sd_q;
  assign ocmd_valid = valid_q;
  assign ocmd_err   = err_q;
  assign ocmd_index = index_q;
  assign ocmd_arg   = arg_q;
  assign oresp_done = done_q;
  assign obusy      = (state_q != IDLE) && (state_q != WAIT_RESP);

endmodule
